// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory target for the MEM stage of the pipelined CPU.
// A request is latched in IDLE, held for LATENCY cycles in total and then
// completed with a one-cycle response pulse.  The MEM stage and earlier stages
// are stalled while the request is outstanding.  Storage is a word array with
// per-byte write enables; its contents survive reset.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  cycles from acceptance to response (1..15)
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-low reset
//   req_valid_i   request present
//   req_write_i   1 = store, 0 = load
//   req_addr_i    byte address
//   req_be_i      store byte enables
//   req_wdata_i   store data
//   req_ready_o   block accepts a request this cycle
//   stall_o       hold the MEM stage and earlier stages
//   resp_valid_o  one-cycle completion pulse
//   resp_rdata_o  load data (meaningful with resp_valid_o)
//   resp_err_o    illegal request (meaningful with resp_valid_o)
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [3:0]  req_be_i,
   input  logic [31:0] req_wdata_i,
   output logic        req_ready_o,
   output logic        stall_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic [31:0] r_resp_rdata;
   logic [31:0] r_mem [DEPTH];

   logic [31:0] w_sel_addr;
   logic        w_sel_write;
   logic        w_sel_err;
   logic [31:0] w_sel_rdata;

   // Misaligned, or word index beyond the array.
   function automatic logic f_illegal(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
   endfunction

   function automatic logic [AW-1:0] f_idx(input logic [31:0] addr);
      return addr[AW+1:2];
   endfunction

   // With LATENCY = 1 the response is formed straight from the inputs in IDLE;
   // otherwise it is formed from the latched request at the end of WAIT.
   assign w_sel_addr  = (r_state == IDLE) ? req_addr_i  : r_addr;
   assign w_sel_write = (r_state == IDLE) ? req_write_i : r_write;
   assign w_sel_err   = f_illegal(w_sel_addr);
   assign w_sel_rdata = (w_sel_err || w_sel_write) ? 32'h0000_0000
                                                   : r_mem[f_idx(w_sel_addr)];

   assign req_ready_o  = (r_state == IDLE);
   assign stall_o      = ((r_state == IDLE) && req_valid_i) || (r_state == WAIT);
   assign resp_valid_o = r_resp_valid;
   assign resp_rdata_o = r_resp_rdata;
   assign resp_err_o   = r_resp_err;

   // Request FSM: accept, count down the latency, present the response.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= IDLE;
         r_cnt        <= 4'd0;
         r_write      <= 1'b0;
         r_addr       <= 32'h0000_0000;
         r_be         <= 4'b0000;
         r_wdata      <= 32'h0000_0000;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'h0000_0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  r_write <= req_write_i;
                  r_addr  <= req_addr_i;
                  r_be    <= req_be_i;
                  r_wdata <= req_wdata_i;
                  r_cnt   <= 4'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= w_sel_err;
                     r_resp_rdata <= w_sel_rdata;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // WAIT spans LATENCY-1 cycles so the acceptance cycle counts
               // as the first cycle of the latency.
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= w_sel_err;
                  r_resp_rdata <= w_sel_rdata;
               end
            end
            RESP: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= 32'h0000_0000;
            end
            default: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= 32'h0000_0000;
            end
         endcase
      end
   end

   // Store commit on the edge that ends RESP; a reset in flight leaves IDLE,
   // so an interrupted store never lands.
   always_ff @(posedge clk_i) begin
      if ((r_state == RESP) && r_write && !r_resp_err) begin
         for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
               r_mem[f_idx(r_addr)][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        v  [3];
   logic        w  [3];
   logic [31:0] a  [3];
   logic [3:0]  be [3];
   logic [31:0] wd [3];
   logic        rdy [3];
   logic        stl [3];
   logic        rv  [3];
   logic [31:0] rd  [3];
   logic        er  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // instance 0: LATENCY 3, instance 1: LATENCY 1, instance 2: LATENCY 15
   dmem_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(v[0]), .req_write_i(w[0]),
      .req_addr_i(a[0]), .req_be_i(be[0]), .req_wdata_i(wd[0]),
      .req_ready_o(rdy[0]), .stall_o(stl[0]), .resp_valid_o(rv[0]),
      .resp_rdata_o(rd[0]), .resp_err_o(er[0]));
   dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(v[1]), .req_write_i(w[1]),
      .req_addr_i(a[1]), .req_be_i(be[1]), .req_wdata_i(wd[1]),
      .req_ready_o(rdy[1]), .stall_o(stl[1]), .resp_valid_o(rv[1]),
      .resp_rdata_o(rd[1]), .resp_err_o(er[1]));
   dmem_responder #(.DEPTH(1024), .LATENCY(15)) u_l15 (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(v[2]), .req_write_i(w[2]),
      .req_addr_i(a[2]), .req_be_i(be[2]), .req_wdata_i(wd[2]),
      .req_ready_o(rdy[2]), .stall_o(stl[2]), .resp_valid_o(rv[2]),
      .resp_rdata_o(rd[2]), .resp_err_o(er[2]));

   function automatic int lat_of(input int k);
      case (k)
         0:       return 3;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   function automatic logic illegal(input logic [31:0] addr);
      return ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'd1024);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // age = -1 : idle; age = n : n cycles after the acceptance cycle.
   int          age [3];
   logic        m_w  [3];
   logic [31:0] m_a  [3];
   logic [3:0]  m_be [3];
   logic [31:0] m_wd [3];
   logic [31:0] mmem [3][1024];

   always @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < 3; k++) age[k] <= -1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (age[k] < 0) begin
               if (v[k]) begin
                  m_w[k]  <= w[k];
                  m_a[k]  <= a[k];
                  m_be[k] <= be[k];
                  m_wd[k] <= wd[k];
                  age[k]  <= 1;
               end
            end else if (age[k] == lat_of(k)) begin
               if (m_w[k] && !illegal(m_a[k])) begin
                  for (int b = 0; b < 4; b++)
                     if (m_be[k][b]) mmem[k][m_a[k] / 32'd4][8*b +: 8] <= m_wd[k][8*b +: 8];
               end
               age[k] <= -1;
            end else begin
               age[k] <= age[k] + 1;
            end
         end
      end
   end

   // Compare every instance against the model on each falling edge.
   always @(negedge clk) begin
      if (rst_i) begin
         for (int k = 0; k < 3; k++) begin
            logic        e_rv;
            logic        e_err;
            logic [31:0] e_rd;
            e_rv = (age[k] == lat_of(k));
            check($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(age[k] < 0));
            check($sformatf("stall[%0d]", k), 32'(stl[k]),
                  32'(((age[k] < 0) && v[k]) || ((age[k] >= 1) && (age[k] < lat_of(k)))));
            check($sformatf("resp_valid[%0d]", k), 32'(rv[k]), 32'(e_rv));
            if (e_rv) begin
               e_err = illegal(m_a[k]);
               e_rd  = (e_err || m_w[k]) ? 32'h0 : mmem[k][m_a[k] / 32'd4];
               check($sformatf("resp_err[%0d]", k), 32'(er[k]), 32'(e_err));
               check($sformatf("resp_rdata[%0d]", k), rd[k], e_rd);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Called just after a rising edge with instance k idle.
   task automatic do_req(input int k, input logic wr, input logic [31:0] ad,
                         input logic [3:0] bem, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic err, output int lat);
      bit got;
      v[k] = 1'b1; w[k] = wr; a[k] = ad; be[k] = bem; wd[k] = wdat;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (rdy[k]) got = 1'b1;
      end
      @(posedge clk); #1;
      v[k] = 1'b0;
      rdat = 32'hFFFF_FFFF; err = 1'bx; lat = -1;
      if (got) begin
         for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (rv[k]) begin
               lat = n; rdat = rd[k]; err = er[k];
            end
         end
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL timeout[%0d]: no response for addr 0x%08h", k, ad);
      end
   endtask

   logic [31:0] r_d;
   logic        r_e;
   int          r_l;
   int          pulses;
   logic [9:0]  rdy_pat;

   initial begin
      rst_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0; w[k] = 1'b0; a[k] = 32'h0; be[k] = 4'h0; wd[k] = 32'h0;
      end
      #12;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'd1);
         check($sformatf("rst_valid[%0d]", k), 32'(rv[k]), 32'd0);
         check($sformatf("rst_rdata[%0d]", k), rd[k], 32'h0);
         check($sformatf("rst_err[%0d]", k), 32'(er[k]), 32'd0);
      end
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;

      // store / load with latency 3
      do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, r_d, r_e, r_l);
      check("st_lat", 32'(r_l), 32'd3);
      check("st_err", 32'(r_e), 32'd0);
      check("st_rdata", r_d, 32'h0);
      do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, r_d, r_e, r_l);
      check("ld_0x10", r_d, 32'hDEADBEEF);

      // byte enables
      do_req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, r_d, r_e, r_l);
      do_req(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, r_d, r_e, r_l);
      do_req(0, 1'b0, 32'h20, 4'h0, 32'h0, r_d, r_e, r_l);
      check("ld_be", r_d, 32'h11BB33DD);

      // illegal requests
      do_req(0, 1'b0, 32'h22, 4'h0, 32'h0, r_d, r_e, r_l);
      check("mis_err", 32'(r_e), 32'd1);
      check("mis_rdata", r_d, 32'h0);
      do_req(0, 1'b1, 32'h0, 4'hF, 32'h5A5A5A5A, r_d, r_e, r_l);
      do_req(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, r_d, r_e, r_l);
      check("oor_err", 32'(r_e), 32'd1);
      do_req(0, 1'b0, 32'h0, 4'h0, 32'h0, r_d, r_e, r_l);
      check("ld_word0", r_d, 32'h5A5A5A5A);

      // reset during WAIT of a store
      do_req(0, 1'b1, 32'h30, 4'hF, 32'h0, r_d, r_e, r_l);
      v[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h30; be[0] = 4'hF; wd[0] = 32'hCAFEF00D;
      @(negedge clk);
      @(posedge clk); #1;
      v[0] = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      check("mid_rst_ready", 32'(rdy[0]), 32'd1);
      check("mid_rst_stall", 32'(stl[0]), 32'd0);
      check("mid_rst_valid", 32'(rv[0]), 32'd0);
      check("mid_rst_rdata", rd[0], 32'h0);
      check("mid_rst_err", 32'(er[0]), 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1'b0, 32'h30, 4'h0, 32'h0, r_d, r_e, r_l);
      check("ld_after_rst", r_d, 32'h0);

      // held request, latency 1
      v[1] = 1'b1; w[1] = 1'b1; a[1] = 32'h40; be[1] = 4'hF; wd[1] = 32'h12345678;
      pulses = 0; rdy_pat = 10'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rv[1]) pulses++;
         rdy_pat[i] = rdy[1];
      end
      @(posedge clk); #1;
      v[1] = 1'b0;
      check("l1_pulses", 32'(pulses), 32'd5);
      check("l1_ready_pattern", 32'(rdy_pat), 32'h155);

      // latency 15 boundary
      do_req(2, 1'b1, 32'h8, 4'hF, 32'h0BADF00D, r_d, r_e, r_l);
      check("l15_st_lat", 32'(r_l), 32'd15);
      do_req(2, 1'b0, 32'h8, 4'h0, 32'h0, r_d, r_e, r_l);
      check("l15_ld_lat", 32'(r_l), 32'd15);
      check("l15_ld", r_d, 32'h0BADF00D);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
